sync_fifo_param: RTL

//  Parametrised single-clock FIFO, successor to the fixed 8x32 FIFO used between SoC bus masters and

---
 rtl/sync_fifo_param_if.sv | 29 ++
 rtl/sync_fifo_param.sv | 84 ++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle for sync_fifo_param; master drives requests, slave (the FIFO) drives status.
interface sync_fifo_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
);
    logic              wr;
    logic [DATA_W-1:0] w_data;
    logic              rd;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              err_clr;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr, w_data, rd, err_clr,
        input  r_data, r_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  wr, w_data, rd, err_clr,
        output r_data, r_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with level, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle read.
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned AF_THRESH = 6,
    parameter int unsigned AE_THRESH = 1
) (
    input logic             clk,
    input logic             rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int unsigned     DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] AF_LVL = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_LVL = AE_THRESH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              full;
    logic              empty;
    logic              rd_acc;
    logic              wr_acc;

    // level never exceeds DEPTH, so its MSB alone marks full
    assign full   = level_q[ADDR_W];
    assign empty  = (level_q == '0);
    assign rd_acc = bus.rd & ~empty;
    assign wr_acc = bus.wr & (~full | rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.w_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            level_q     <= level_q + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, rd_acc};
            // a new error in the same cycle as err_clr keeps the flag set
            overflow_q  <= (overflow_q  & ~bus.err_clr) | (bus.wr & ~wr_acc);
            underflow_q <= (underflow_q & ~bus.err_clr) | (bus.rd & ~rd_acc);
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.r_data  = mem[rd_ptr];
    assign bus.r_valid = ~empty;
`else
    logic [DATA_W-1:0] r_data_q;
    logic              r_valid_q;

    // non-blocking read returns the old word when the same slot is written this edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= rd_acc;
            if (rd_acc) r_data_q <= mem[rd_ptr];
        end
    end

    assign bus.r_data  = r_data_q;
    assign bus.r_valid = r_valid_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (level_q >= AF_LVL);
    assign bus.almost_empty = (level_q <= AE_LVL);
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule
